// File: rtl/tl_uart_tx.sv
// rtl/tl_uart_tx.sv - TileLink-UL UART transmitter (8N1, LSB first) with a TX FIFO.
// Define UART_TX_RUNTIME_DIV_EN to make the DIV register writable; otherwise the divisor is CLK_DIV.
module tl_uart_tx #(
  parameter int XLEN       = 32,
  parameter int SID_WIDTH  = 2,
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tl_a_valid,
  output logic                 tl_a_ready,
  input  logic [2:0]           tl_a_opcode,
  input  logic [2:0]           tl_a_param,
  input  logic [2:0]           tl_a_size,
  input  logic [SID_WIDTH-1:0] tl_a_source,
  input  logic [XLEN-1:0]      tl_a_address,
  input  logic [XLEN/8-1:0]    tl_a_mask,
  input  logic [XLEN-1:0]      tl_a_data,
  output logic                 tl_d_valid,
  input  logic                 tl_d_ready,
  output logic [2:0]           tl_d_opcode,
  output logic [1:0]           tl_d_param,
  output logic [2:0]           tl_d_size,
  output logic [SID_WIDTH-1:0] tl_d_source,
  output logic [XLEN-1:0]      tl_d_data,
  output logic                 tl_d_corrupt,
  output logic                 tl_d_denied,
  output logic                 uart_tx,
  output logic                 tx_empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   DIV_RESET = 16'(CLK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [15:0]     bitcnt_q, bitcnt_d;
  logic [15:0]     divl_q, divl_d;
  logic [2:0]      bitidx_q, bitidx_d;
  logic [7:0]      shreg_q, shreg_d;

  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;

  logic            d_valid_q, d_denied_q;
  logic [2:0]      d_opcode_q, d_size_q;
  logic [SID_WIDTH-1:0] d_source_q;
  logic [XLEN-1:0] d_data_q;

  logic            a_fire, is_get, is_put, bad_req;
  logic            fifo_full, fifo_empty, busy;
  logic            push_req, push, pop, ovf_set, ovf_clr, start_frame;
  logic [1:0]      offset;
  logic [XLEN-1:0] rdata;
  logic [15:0]     div_eff, div_rd;
  logic            unused_inputs;

  assign unused_inputs = ^{tl_a_param, tl_a_address, tl_a_mask, tl_a_data};

  assign tl_a_ready = !d_valid_q;
  assign a_fire     = tl_a_valid & tl_a_ready;
  assign offset     = tl_a_address[3:2];
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    is_put   = (tl_a_opcode == 3'd0) || (tl_a_opcode == 3'd1);
    is_get   = (tl_a_opcode == 3'd4);
    bad_req  = !(is_put || is_get) || (offset == 2'd3);
    push_req = a_fire & is_put & ~bad_req & (offset == 2'd0) & tl_a_mask[0];
    // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
    push     = push_req & ~fifo_full;
    ovf_set  = push_req & fifo_full;
    ovf_clr  = a_fire & is_put & ~bad_req & (offset == 2'd1) & tl_a_mask[0] & tl_a_data[3];
  end

`ifdef UART_TX_RUNTIME_DIV_EN
  logic [15:0] div_q, div_wr;
  logic        div_we;

  always_comb begin
    div_wr = div_q;
    if (tl_a_mask[0]) div_wr[7:0]  = tl_a_data[7:0];
    if (tl_a_mask[1]) div_wr[15:8] = tl_a_data[15:8];
    if (div_wr < 16'd2) div_wr = 16'd2;
  end

  assign div_we = a_fire & is_put & ~bad_req & (offset == 2'd2);

  always_ff @(posedge clk) begin
    if (!reset)      div_q <= DIV_RESET;
    else if (div_we) div_q <= div_wr;
  end

  assign div_eff = div_q;
  assign div_rd  = div_q;
`else
  assign div_eff = DIV_RESET;
  assign div_rd  = 16'd0;
`endif

  always_comb begin
    rdata = '0;
    case (offset)
      2'd0: rdata[31] = fifo_full;
      2'd1: begin
        rdata[0]      = busy;
        rdata[1]      = fifo_full;
        rdata[2]      = fifo_empty;
        rdata[3]      = overflow_q;
        rdata[8 +: CW] = count_q;
      end
      2'd2: rdata[15:0] = div_rd;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      d_valid_q  <= 1'b0;
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
      d_denied_q <= 1'b0;
    end else if (a_fire) begin
      d_valid_q  <= 1'b1;
      d_opcode_q <= is_get ? 3'd1 : 3'd0;
      d_size_q   <= tl_a_size;
      d_source_q <= tl_a_source;
      d_data_q   <= (is_get && !bad_req) ? rdata : '0;
      d_denied_q <= bad_req | ovf_set;
    end else if (d_valid_q && tl_d_ready) begin
      d_valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= tl_a_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (ovf_set)      overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      divl_q   <= DIV_RESET;
      bitidx_q <= '0;
      shreg_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      divl_q   <= divl_d;
      bitidx_q <= bitidx_d;
      shreg_q  <= shreg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    divl_d      = divl_q;
    bitidx_d    = bitidx_q;
    shreg_d     = shreg_q;
    start_frame = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) start_frame = 1'b1;
      end
      S_START: begin
        if (bitcnt_q == '0) begin
          state_d  = S_DATA;
          bitidx_d = '0;
          bitcnt_d = divl_q - 16'd1;
        end else begin
          bitcnt_d = bitcnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bitcnt_q == '0) begin
          bitcnt_d = divl_q - 16'd1;
          shreg_d  = {1'b0, shreg_q[7:1]};
          if (bitidx_q == 3'd7) state_d  = S_STOP;
          else                  bitidx_d = bitidx_q + 3'd1;
        end else begin
          bitcnt_d = bitcnt_q - 16'd1;
        end
      end
      S_STOP: begin
        // Back-to-back frames: a waiting byte starts right after the stop bit.
        if (bitcnt_q == '0) begin
          if (!fifo_empty) start_frame = 1'b1;
          else             state_d     = S_IDLE;
        end else begin
          bitcnt_d = bitcnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start_frame) begin
      state_d  = S_START;
      shreg_d  = fifo_q[rptr_q];
      divl_d   = div_eff;
      bitcnt_d = div_eff - 16'd1;
    end
    pop = start_frame;
  end

  always_comb begin
    case (state_q)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = shreg_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  assign tx_empty     = fifo_empty && (state_q == S_IDLE);
  assign tl_d_valid   = d_valid_q;
  assign tl_d_opcode  = d_opcode_q;
  assign tl_d_param   = 2'd0;
  assign tl_d_size    = d_size_q;
  assign tl_d_source  = d_source_q;
  assign tl_d_data    = d_data_q;
  assign tl_d_corrupt = 1'b0;
  assign tl_d_denied  = d_denied_q;

endmodule

// File: tb/tb_tl_uart_tx.sv
// tb/tb_tl_uart_tx.sv - randomized bench for tl_uart_tx against a frame-level reference model.
`timescale 1ns/1ps
module tb_tl_uart_tx;
  localparam int XLEN  = 32;
  localparam int SIDW  = 2;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            tl_a_valid = 1'b0;
  logic            tl_a_ready;
  logic [2:0]      tl_a_opcode = '0;
  logic [2:0]      tl_a_param = '0;
  logic [2:0]      tl_a_size = '0;
  logic [SIDW-1:0] tl_a_source = '0;
  logic [XLEN-1:0] tl_a_address = '0;
  logic [3:0]      tl_a_mask = '0;
  logic [XLEN-1:0] tl_a_data = '0;
  logic            tl_d_valid;
  logic            tl_d_ready = 1'b0;
  logic [2:0]      tl_d_opcode;
  logic [1:0]      tl_d_param;
  logic [2:0]      tl_d_size;
  logic [SIDW-1:0] tl_d_source;
  logic [XLEN-1:0] tl_d_data;
  logic            tl_d_corrupt;
  logic            tl_d_denied;
  logic            uart_tx;
  logic            tx_empty;

  always #5 clk = ~clk;

  tl_uart_tx #(.XLEN(XLEN), .SID_WIDTH(SIDW), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
    .tl_a_param(tl_a_param), .tl_a_size(tl_a_size), .tl_a_source(tl_a_source),
    .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask), .tl_a_data(tl_a_data),
    .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready), .tl_d_opcode(tl_d_opcode),
    .tl_d_param(tl_d_param), .tl_d_size(tl_d_size), .tl_d_source(tl_d_source),
    .tl_d_data(tl_d_data), .tl_d_corrupt(tl_d_corrupt), .tl_d_denied(tl_d_denied),
    .uart_tx(uart_tx), .tx_empty(tx_empty)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a byte queue plus a frame in flight described only by its start time.
  logic [7:0]  mq[$];
  bit          m_ovf;
  int          m_div = DIV;
  bit          m_active;
  int          m_pos, m_fdiv;
  logic [7:0]  m_byte;
  bit          m_dvalid;
  logic [2:0]  m_dop, m_dsize;
  logic        m_dden;
  logic [31:0] m_ddata;
  logic [SIDW-1:0] m_dsrc;
  bit          f_fire, f_full, f_get, f_put, f_bad;
  int          f_off, f_n;
  logic [15:0] f_nd;

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / m_fdiv;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  always @(posedge clk) begin
    cyc++;
    started = 1;
    if (!reset) begin
      mq.delete();
      m_ovf = 0; m_div = DIV; m_active = 0; m_pos = 0; m_dvalid = 0;
    end else begin
      f_fire = tl_a_valid && !m_dvalid;
      f_n    = mq.size();
      f_full = (f_n == DEPTH);
      f_off  = int'(tl_a_address[3:2]);
      f_get  = (tl_a_opcode == 3'd4);
      f_put  = (tl_a_opcode == 3'd0) || (tl_a_opcode == 3'd1);
      f_bad  = !(f_get || f_put) || (f_off == 3);
      if (f_fire) begin
        m_dvalid = 1;
        m_dop    = f_get ? 3'd1 : 3'd0;
        m_dsize  = tl_a_size;
        m_dsrc   = tl_a_source;
        m_dden   = f_bad || (f_put && f_off == 0 && tl_a_mask[0] && f_full);
        m_ddata  = 0;
        if (f_get && !f_bad) begin
          if (f_off == 0) m_ddata = f_full ? 32'h8000_0000 : 32'h0;
          if (f_off == 1) m_ddata = (f_n << 8) + (m_ovf << 3) + ((f_n == 0) << 2) + (f_full << 1) + m_active;
`ifdef UART_TX_RUNTIME_DIV_EN
          if (f_off == 2) m_ddata = m_div;
`endif
        end
      end else if (m_dvalid && tl_d_ready) begin
        m_dvalid = 0;
      end
      if (m_active) begin
        m_pos++;
        if (m_pos == 10 * m_fdiv) m_active = 0;
      end
      if (!m_active && f_n > 0) begin
        m_byte = mq.pop_front();
        m_active = 1; m_pos = 0; m_fdiv = m_div;
      end
      if (f_fire && f_put && !f_bad) begin
        if (f_off == 0 && tl_a_mask[0]) begin
          if (f_full) m_ovf = 1;
          else        mq.push_back(tl_a_data[7:0]);
        end
        if (f_off == 1 && tl_a_mask[0] && tl_a_data[3]) m_ovf = 0;
`ifdef UART_TX_RUNTIME_DIV_EN
        if (f_off == 2) begin
          f_nd = m_div[15:0];
          if (tl_a_mask[0]) f_nd[7:0]  = tl_a_data[7:0];
          if (tl_a_mask[1]) f_nd[15:8] = tl_a_data[15:8];
          m_div = (f_nd < 2) ? 2 : int'(f_nd);
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("a_ready", tl_a_ready, !m_dvalid);
      chk("d_valid", tl_d_valid, m_dvalid);
      chk("uart_tx", uart_tx, exp_tx());
      chk("tx_empty", tx_empty, (!m_active && mq.size() == 0));
      if (m_dvalid) begin
        chk("d_opcode", tl_d_opcode, m_dop);
        chk("d_data", tl_d_data, m_ddata);
        chk("d_denied", tl_d_denied, m_dden);
        chk("d_size", tl_d_size, m_dsize);
        chk("d_source", tl_d_source, m_dsrc);
        chk("d_param", tl_d_param, 0);
        chk("d_corrupt", tl_d_corrupt, 0);
      end
    end
  end

  logic [31:0] rd;
  logic        den;
  logic [2:0]  dop, dsz;
  logic [SIDW-1:0] dsrc;

  // Called #1 after an edge with no D outstanding; returns #1 after the D-fire edge.
  task automatic tl_op(input logic [2:0] op, input logic [3:0] off4, input logic [3:0] mask,
                       input logic [31:0] data, input int hold,
                       input logic [SIDW-1:0] src, input logic [2:0] size);
    logic [31:0] cap;
    tl_a_valid   = 1'b1;
    tl_a_opcode  = op;
    tl_a_param   = 3'($urandom);
    tl_a_address = {$urandom} & 32'hFFFF_FFF0 | {28'd0, off4};
    tl_a_mask    = mask;
    tl_a_data    = data;
    tl_a_source  = src;
    tl_a_size    = size;
    @(posedge clk); #1;
    tl_a_valid = 1'b0;
    chk("d_latency", tl_d_valid, 1);
    rd = tl_d_data; den = tl_d_denied; dop = tl_d_opcode; dsz = tl_d_size; dsrc = tl_d_source;
    cap = tl_d_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_a_ready", tl_a_ready, 0);
      chk("hold_d_data", tl_d_data, cap);
    end
    tl_d_ready = 1'b1;
    @(posedge clk); #1;
    tl_d_ready = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (!tx_empty && n < 3000) begin @(posedge clk); #1; n++; end
  endtask

  int c0;
  logic [9:0] pat;
  logic [2:0] rop;
  logic [3:0] roff;
  logic [31:0] rdat;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ready", tl_a_ready, 1);
    chk("rst_d_valid", tl_d_valid, 0);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_tx_empty", tx_empty, 1);
    chk("rst_d_fields", {tl_d_opcode, tl_d_size, tl_d_source, tl_d_denied, tl_d_data}, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 0x55 frame, sampled mid-bit
    tl_op(3'd0, 4'h0, 4'hF, 32'h55, 0, 2'd1, 3'd2);
    chk("t1_denied", den, 0);
    chk("t1_opcode", dop, 0);
    c0 = cyc;
    pat = 10'b10_1010_1010;
    for (int k = 0; k < 10; k++) begin
      wait_cyc(c0 + 4 * k + 2);
      chk("t1_bit", uart_tx, pat[k]);
    end
    wait_cyc(c0 + 39);
    chk("t1_busy_end", tx_empty, 0);
    wait_cyc(c0 + 40);
    chk("t1_empty_end", tx_empty, 1);

    // overflow while the first byte is on the line
    tl_op(3'd0, 4'h0, 4'hF, 32'h11, 0, 2'd0, 3'd0);
    c0 = cyc;
    for (int i = 0; i < 5; i++) begin
      tl_op(3'd1, 4'h0, 4'h1, 32'h20 + i, 0, 2'd0, 3'd0);
      chk("t2_push_denied", den, (i == 4));
    end
    tl_op(3'd4, 4'h4, 4'hF, 0, 0, 2'd3, 3'd2);
    chk("t2_status", rd, 32'h0000_040B);
    wait_empty();
    chk("t2_drain_cycles", cyc - c0, 200);
    tl_op(3'd0, 4'h4, 4'h1, 32'h8, 0, 2'd0, 3'd2);
    chk("t2_clear_denied", den, 0);

    // STATUS read with D back-pressure
    tl_op(3'd4, 4'h4, 4'hF, 0, 3, 2'd2, 3'd2);
    chk("t3_data", rd, 32'h4);
    chk("t3_opcode", dop, 1);
    chk("t3_source", dsrc, 2);
    chk("t3_size", dsz, 2);

    // error responses
    tl_op(3'd4, 4'hC, 4'hF, 0, 0, 2'd1, 3'd2);
    chk("t4_rsv_denied", den, 1);
    chk("t4_rsv_opcode", dop, 1);
    chk("t4_rsv_data", rd, 0);
    tl_op(3'd2, 4'h0, 4'hF, 32'h77, 0, 2'd1, 3'd2);
    chk("t4_arith_denied", den, 1);
    chk("t4_arith_opcode", dop, 0);
    tl_op(3'd4, 4'h4, 4'hF, 0, 0, 2'd0, 3'd2);
    chk("t4_status", rd, 32'h4);

    // reset in the middle of DATA
    tl_op(3'd0, 4'h0, 4'hF, 32'hA5, 0, 2'd0, 3'd0);
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t5_uart_tx", uart_tx, 1);
    chk("t5_tx_empty", tx_empty, 1);
    chk("t5_d_valid", tl_d_valid, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    tl_op(3'd4, 4'h4, 4'hF, 0, 0, 2'd0, 3'd2);
    chk("t5_status", rd, 32'h4);
    tl_op(3'd0, 4'h0, 4'hF, 32'h3C, 0, 2'd0, 3'd0);
    c0 = cyc;
    wait_empty();
    chk("t5_frame_cycles", cyc - c0, 40);

    // DIV register
    tl_op(3'd0, 4'h8, 4'hF, 32'h1, 0, 2'd0, 3'd2);
    chk("t6_div_wr_denied", den, 0);
    tl_op(3'd4, 4'h8, 4'hF, 0, 0, 2'd0, 3'd2);
`ifdef UART_TX_RUNTIME_DIV_EN
    chk("t6_div_read", rd, 2);
`else
    chk("t6_div_read", rd, 0);
`endif
    tl_op(3'd0, 4'h0, 4'hF, 32'h81, 0, 2'd0, 3'd0);
    c0 = cyc;
    wait_empty();
`ifdef UART_TX_RUNTIME_DIV_EN
    chk("t6_frame_cycles", cyc - c0, 20);
`else
    chk("t6_frame_cycles", cyc - c0, 40);
`endif

    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rop = 3'd0;
        4, 5:       rop = 3'd1;
        6, 7, 8:    rop = 3'd4;
        default:    rop = 3'($urandom_range(2, 7));
      endcase
      roff = ($urandom_range(0, 3) == 0) ? 4'(($urandom_range(1, 3)) << 2) : 4'h0;
      rdat = (roff == 4'h8) ? 32'($urandom_range(0, 6)) : $urandom;
      tl_op(rop, roff, 4'($urandom), rdat, $urandom_range(0, 3), 2'($urandom), 3'($urandom));
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(20, 60)) begin @(posedge clk); #1; end
      else repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
    end
    wait_empty();
    repeat (3) begin @(posedge clk); #1; end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
